// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared definitions for the five-stage MIPS control path.
//               Holds the bundle widths, bit positions inside each bundle,
//               bubble constants, the stage-register layouts and the opcode
//               values shared with the decode-stage control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // ---------------------------------------------------------------- widths
    localparam int WB_W  = 2;   // {RegWrite, MemtoReg}
    localparam int M_W   = 3;   // {Branch, MemRead, MemWrite}
    localparam int EX_W  = 4;   // {RegDst, ALUOp[1:0], ALUSrc}
    localparam int REG_W = 5;   // register number

    // ---------------------------------------------------------- bit positions
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUSRC   = 0;

    // ------------------------------------------------------- bubble constants
    localparam logic [WB_W-1:0]  WB_BUBBLE  = '0;
    localparam logic [M_W-1:0]   M_BUBBLE   = '0;
    localparam logic [EX_W-1:0]  EX_BUBBLE  = '0;
    localparam logic [REG_W-1:0] REG_ZERO   = '0;

    // ----------------------------------------- opcodes (decode control unit)
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ------------------------------------------------- stage register layouts
    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [M_W-1:0]   m;
        logic [EX_W-1:0]  ex;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic             valid;
    } idex_t;

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [M_W-1:0]   m;
        logic [REG_W-1:0] dest;
        logic             valid;
    } exmem_t;

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [REG_W-1:0] dest;
        logic             valid;
    } memwb_t;

    localparam int IDEX_W  = $bits(idex_t);
    localparam int EXMEM_W = $bits(exmem_t);
    localparam int MEMWB_W = $bits(memwb_t);

    // ------------------------------------------------------------- sanitising
    // MemtoReg is meaningless without RegWrite; clear it so downstream
    // stages never see a don't-care bit.
    function automatic logic [WB_W-1:0] sanitize_wb(input logic [WB_W-1:0] wb);
        logic [WB_W-1:0] r;
        r              = wb;
        r[WB_MEMTOREG] = wb[WB_REGWRITE] & wb[WB_MEMTOREG];
        return r;
    endfunction

    // RegDst only selects a write destination; without RegWrite it is cleared.
    function automatic logic [EX_W-1:0] sanitize_ex(input logic [EX_W-1:0] ex,
                                                    input logic            regwrite);
        logic [EX_W-1:0] r;
        r            = ex;
        r[EX_REGDST] = regwrite & ex[EX_REGDST];
        return r;
    endfunction

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/ctrl_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_stage_reg
// Description : Generic pipeline stage register. Priority is
//               rst > bubble > load; both rst and bubble clear the register
//               to all zeros, which is the bubble encoding of every stage.
// Revision    : 1.0 - initial release
//
// Ports
//   clk       in  1      rising-edge clock
//   rst       in  1      synchronous active-high reset
//   bubble_i  in  1      replace contents with a bubble this edge
//   load_i    in  1      capture d_i this edge
//   d_i       in  WIDTH  next stage contents
//   q_o       out WIDTH  current stage contents
// ============================================================================
module ctrl_stage_reg
    import mips_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bubble_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q;
    logic [WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = stage_q;
        if (bubble_i) begin
            stage_d = '0;
        end else if (load_i) begin
            stage_d = d_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule : ctrl_stage_reg
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe
// Description : Control-bundle carrier for the five-stage MIPS core. Moves the
//               WB/M/EX bundles from decode through ID/EX, EX/MEM and MEM/WB,
//               inserts a single bubble on a load-use hazard and squashes the
//               two younger stages on a taken branch.
// Revision    : 1.0 - initial release
// Config      : CTRL_HAZARD_DETECT_EN - when defined, load-use detection and
//               bubble insertion are built; when undefined, stall is tied low
//               and ID/EX always captures the ID bundle.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   id_valid              ID stage holds a real instruction
//   id_wb/id_m/id_ex      decode control bundles
//   id_rs/id_rt/id_rd     register fields of the ID instruction
//   flush                 branch taken (resolved in MEM)
//   stall                 hold PC and IF/ID this cycle
//   ex_ctrl/ex_dest       EX bundle and destination of ID/EX
//   mem_ctrl/mem_dest     M bundle and destination of EX/MEM
//   wb_ctrl/wb_dest       WB bundle and destination of MEM/WB
//   ex/mem/wb_valid       stage holds a real instruction
// ============================================================================
module ctrl_pipe
    import mips_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [WB_W-1:0]  id_wb,
    input  logic [M_W-1:0]   id_m,
    input  logic [EX_W-1:0]  id_ex,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             flush,
    output logic             stall,
    output logic [EX_W-1:0]  ex_ctrl,
    output logic [REG_W-1:0] ex_dest,
    output logic [M_W-1:0]   mem_ctrl,
    output logic [REG_W-1:0] mem_dest,
    output logic [WB_W-1:0]  wb_ctrl,
    output logic [REG_W-1:0] wb_dest,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid
);

    idex_t  idex_d;
    idex_t  idex_q;
    exmem_t exmem_d;
    exmem_t exmem_q;
    memwb_t memwb_d;
    memwb_t memwb_q;

    logic   w_load_use;
    logic   w_idex_bubble;
    logic   w_exmem_bubble;

    // ------------------------------------------------------------------------
    // ID capture: an invalid slot becomes a bubble, don't-care bits cleared.
    // ------------------------------------------------------------------------
    always_comb begin
        idex_d = '0;
        if (id_valid) begin
            idex_d.wb    = sanitize_wb(id_wb);
            idex_d.m     = id_m;
            idex_d.ex    = sanitize_ex(id_ex, id_wb[WB_REGWRITE]);
            idex_d.rs    = id_rs;
            idex_d.rt    = id_rt;
            idex_d.rd    = id_rd;
            idex_d.valid = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Load-use detection: the load sitting in ID/EX writes rt; a consumer in
    // ID reading that register must wait one cycle. $zero never hazards.
    // ------------------------------------------------------------------------
`ifdef CTRL_HAZARD_DETECT_EN
    always_comb begin
        w_load_use = id_valid
                   && idex_q.m[M_MEMREAD]
                   && (idex_q.rt != REG_ZERO)
                   && ((idex_q.rt == id_rs) || (idex_q.rt == id_rt));
    end
`else
    assign w_load_use = 1'b0;
`endif

    // A taken branch discards the ID instruction anyway, so stalling it would
    // only hold a squashed instruction; reset forces every output low.
    assign stall = w_load_use & ~flush & ~rst;

    assign w_idex_bubble  = stall | flush;
    assign w_exmem_bubble = flush;

    // ------------------------------------------------------------------------
    // Forward paths between stage registers
    // ------------------------------------------------------------------------
    assign ex_dest = idex_q.ex[EX_REGDST] ? idex_q.rd : idex_q.rt;

    always_comb begin
        exmem_d       = '0;
        exmem_d.wb    = idex_q.wb;
        exmem_d.m     = idex_q.m;
        exmem_d.dest  = ex_dest;
        exmem_d.valid = idex_q.valid;
    end

    always_comb begin
        memwb_d       = '0;
        memwb_d.wb    = exmem_q.wb;
        memwb_d.dest  = exmem_q.dest;
        memwb_d.valid = exmem_q.valid;
    end

    // ------------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------------
    ctrl_stage_reg #(
        .WIDTH (IDEX_W)
    ) u_idex (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (w_idex_bubble),
        .load_i   (1'b1),
        .d_i      (idex_d),
        .q_o      (idex_q)
    );

    ctrl_stage_reg #(
        .WIDTH (EXMEM_W)
    ) u_exmem (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (w_exmem_bubble),
        .load_i   (1'b1),
        .d_i      (exmem_d),
        .q_o      (exmem_q)
    );

    // MEM/WB always advances: on a flush it captures the branch itself.
    ctrl_stage_reg #(
        .WIDTH (MEMWB_W)
    ) u_memwb (
        .clk      (clk),
        .rst      (rst),
        .bubble_i (1'b0),
        .load_i   (1'b1),
        .d_i      (memwb_d),
        .q_o      (memwb_q)
    );

    // rs travels with the instruction for the forwarding unit outside this
    // block; nothing here consumes it.
    logic w_unused_ok;
    assign w_unused_ok = ^idex_q.rs;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ex_ctrl   = idex_q.ex;
    assign ex_valid  = idex_q.valid;
    assign mem_ctrl  = exmem_q.m;
    assign mem_dest  = exmem_q.dest;
    assign mem_valid = exmem_q.valid;
    assign wb_ctrl   = memwb_q.wb;
    assign wb_dest   = memwb_q.dest;
    assign wb_valid  = memwb_q.valid;

endmodule : ctrl_pipe
`default_nettype wire

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipeline control carrier for the five-stage MIPS core. It receives the WB/M/EX control bundles produced by the decode-stage control unit and carries them through the ID/EX, EX/MEM and MEM/WB registers, delivering each field to the stage that uses it. It also performs load-use hazard detection with bubble insertion, and branch flush squashing.

## Interface
- Parameters: none. Register-number width is fixed at 5; widths come from the package.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID stage holds a real instruction.
- `id_wb` in 2: {RegWrite, MemtoReg}.
- `id_m` in 3: {Branch, MemRead, MemWrite}.
- `id_ex` in 4: {RegDst, ALUOp[1:0], ALUSrc}.
- `id_rs`, `id_rt`, `id_rd` in 5 each: register fields of the ID instruction.
- `flush` in 1: branch taken, resolved in MEM.
- `stall` out 1: hold PC and IF/ID this cycle.
- `ex_ctrl` out 4: EX bundle of the ID/EX register.
- `ex_dest` out 5: `RegDst ? rd : rt` from ID/EX.
- `mem_ctrl` out 3: M bundle of EX/MEM. `mem_ctrl[2]` is ANDed externally with the ALU zero flag to form `flush`.
- `mem_dest` out 5: destination register in EX/MEM.
- `wb_ctrl` out 2: WB bundle of MEM/WB.
- `wb_dest` out 5: destination register in MEM/WB.
- `ex_valid`, `mem_valid`, `wb_valid` out 1: stage holds a real instruction.

## Operation
- **Capture sanitising:** don't-care bits in incoming bundles are forced to 0 at capture.
  - MemtoReg is stored as 0 when RegWrite=0.
  - RegDst is stored as 0 when RegWrite=0.
  - Registers never hold X.
- **Bubble:** all control bits 0, dest 0, valid 0.
- **Normal cycle:**
  - ID/EX <= {id bundles, rs, rt, rd, id_valid}.
  - EX/MEM <= {ID/EX WB, ID/EX M, ex_dest, ex_valid}.
  - MEM/WB <= {EX/MEM WB, mem_dest, mem_valid}.
  - A bundle with id_valid=0 is captured as a bubble.
- **Load-use (combinational `stall`):** `stall` = all of the following:
  - id_valid;
  - ID/EX MemRead;
  - ID/EX rt != 0;
  - ID/EX rt == id_rs or ID/EX rt == id_rt.
- **While stall=1:** ID/EX <= bubble; EX/MEM and MEM/WB advance normally. Exactly one bubble is inserted per load-use pair.
- **Flush:** ID/EX <= bubble, EX/MEM <= bubble, MEM/WB advances normally (it captures the branch itself). `stall` is forced to 0 while flush=1.
- **flush and load-use in the same cycle:** flush wins.
- **Reset:** all three stage registers become bubbles. Every output is 0, including `stall`. Reset overrides flush and stall.
- **Reset mid-stall:** the pipeline is empty on the next cycle and no stale stall remains.

## Timing
- A bundle accepted at edge N appears on `ex_*` in cycle N+1, `mem_*` in N+2 and `wb_*` in N+3.
- `stall` and `ex_dest` are combinational from registered state and ID inputs. There is no combinational path from `flush` to any registered output except through `stall`.
- A consumer dependent on a load resumes one cycle later; the load is then in MEM/WB for forwarding.
- Throughput is one instruction per cycle absent hazards.

## Configuration
- Macro: `CTRL_HAZARD_DETECT_EN`.
- **Defined:** load-use detection and bubble insertion behave as above.
- **Undefined:** `stall` is tied to 0 and ID/EX always captures the ID bundle. Software must insert NOPs after loads. Flush behaviour is unchanged.

## Structure
- **Package `mips_ctrl_pkg`:**
  - Bundle widths (2/3/4).
  - Bit-position localparams (WB_REGWRITE=1, WB_MEMTOREG=0, M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0, EX_REGDST=3, EX_ALUSRC=0).
  - Bubble constants.
  - Opcode constants shared with the decode control unit.
- **Sub-module `ctrl_stage_reg`:** parameterised-width register with synchronous `rst`, `bubble` and `load` inputs. It is instantiated three times.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with random inputs -> all outputs 0 and `stall`=0.
- **R-type flow:** id_wb=2'b10, id_m=0, id_ex=4'b1100, rd=5, rt=3, valid.
  - ex_dest=5 at N+1.
  - mem_dest=5 at N+2.
  - wb_ctrl=2'b10, wb_dest=5, wb_valid=1 at N+3.
- **Load-use:**
  - lw: id_wb=11, id_m=010, id_ex=0001, rt=8.
  - Next instruction: rs=8.
  - Expect `stall`=1 for exactly one cycle and one bubble at ex_valid=0.
  - The dependent instruction reaches EX one cycle later. With the macro undefined, `stall` stays 0.
- **Load followed by rt=0 use:** lw with rt=0, next instruction rs=0 -> `stall`=0.
- **Branch flush:**
  - beq reaches MEM; drive `flush`=1.
  - The next cycle shows ex_valid=0 and mem_valid=0.
  - MEM/WB holds beq with wb_ctrl=00.
- **Flush+load-use collision:** assert `flush` the same cycle as a load-use match -> `stall`=0, both stages bubbled.
- **Sanitising:** sw with id_wb=2'b0x and id_ex=4'bx001 -> wb_ctrl=00 and ex_ctrl=4'b0001, no X on any output.
